// File: rtl/ycr1_wbm_burst_ctrl_if.sv
// ---------------------------------------------------------------------------
// ycr1_wbm_burst_ctrl_if
//   Wishbone burst bus between the burst controller and the async Wishbone
//   bridge. Signal names keep the controller's point of view (_o driven by
//   the master, _i driven by the slave).
//
//   master modport : burst controller side
//   slave  modport : bridge / bus-model side
//
//   wbm_cyc_o, wbm_stb_o : cycle / strobe
//   wbm_adr_o            : burst start address, word aligned
//   wbm_we_o             : write
//   wbm_dat_o            : write data
//   wbm_sel_o            : byte enables
//   wbm_bl_o             : burst length in beats
//   wbm_dat_i            : read data
//   wbm_ack_i            : beat ack
//   wbm_lack_i           : last-beat ack
//   wbm_err_i            : bus error
// ---------------------------------------------------------------------------
interface ycr1_wbm_burst_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4,
    parameter int BL = 10
) ();
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic [AW-1:0] wbm_adr_o;
    logic          wbm_we_o;
    logic [DW-1:0] wbm_dat_o;
    logic [BW-1:0] wbm_sel_o;
    logic [BL-1:0] wbm_bl_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_lack_i;
    logic          wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o, wbm_bl_o,
        input  wbm_dat_i, wbm_ack_i, wbm_lack_i, wbm_err_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o, wbm_bl_o,
        output wbm_dat_i, wbm_ack_i, wbm_lack_i, wbm_err_i
    );
endinterface

// File: rtl/ycr1_wbm_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ycr1_wbm_burst_ctrl
//   Wishbone burst master in the wbm_clk_i domain. Turns one cache-line
//   refill (read) or writeback (write) request into a single Wishbone burst
//   of wbm_bl_o beats terminated by wbm_lack_i, streams read beats out,
//   pulls write beats in, and reports completion with error status.
//
// Ports
//   wbm_rst_n, wbm_clk_i      : async active-low reset, clock
//   req_valid_i / req_ready_o : request handshake
//   req_we_i, req_addr_i, req_len_i : request direction, byte address, beats
//   wr_data_i, wr_pop_o, wr_idx_o   : write beat source (indexed by wr_idx_o)
//   rd_valid_o, rd_data_o, rd_idx_o, rd_last_o : read beat stream
//   done_o, err_o, proto_err_o : completion pulse and status (valid with done_o)
//   tmo_o                      : timeout status (optional feature only)
//   dbg_state_o                : current FSM state for observation
//   wbm                        : Wishbone burst bus (master modport)
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; req_we_i/req_addr_i/req_len_i must be stable
// while req_valid_i is high. req_ready_o is high only in IDLE.
//
// Optional feature (macro YCR1_WBM_BURST_TMO_EN): a TMO_W-bit watchdog that
// aborts a burst when no ack arrives for 2^TMO_W-1 burst cycles.
// ---------------------------------------------------------------------------
module ycr1_wbm_burst_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int BW = 4,
    parameter int BL = 10
`ifdef YCR1_WBM_BURST_TMO_EN
    ,
    parameter int TMO_W = 8
`endif
) (
    input  logic          wbm_rst_n,
    input  logic          wbm_clk_i,

    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [BL-1:0] req_len_i,

    input  logic [DW-1:0] wr_data_i,
    output logic          wr_pop_o,
    output logic [BL-1:0] wr_idx_o,

    output logic          rd_valid_o,
    output logic [DW-1:0] rd_data_o,
    output logic [BL-1:0] rd_idx_o,
    output logic          rd_last_o,

    output logic          done_o,
    output logic          err_o,
    output logic          proto_err_o,
`ifdef YCR1_WBM_BURST_TMO_EN
    output logic          tmo_o,
`endif
    output logic [1:0]    dbg_state_o,

    ycr1_wbm_burst_ctrl_if.master wbm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [BL-1:0] len_q;
    logic [BL-1:0] beat_cnt_q;
    logic          err_q;
    logic          proto_q;

    logic          accept;
    logic          in_burst;
    logic          beat_ok;
    logic          ack_ok;
    logic          tmo_hit;

    assign accept   = req_valid_i & (state_q == ST_IDLE);
    assign in_burst = (state_q == ST_BURST);
    // beat_cnt saturates at len, so equality means every requested beat is in.
    assign beat_ok  = (beat_cnt_q != len_q);
    assign ack_ok   = in_burst & wbm.wbm_ack_i & beat_ok;

`ifdef YCR1_WBM_BURST_TMO_EN
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_q;

    // Counter would reach all ones at the end of this cycle: leave BURST on
    // the same edge so exactly 2^TMO_W-1 burst cycles elapse without an ack.
    assign tmo_hit = in_burst & ~wbm.wbm_ack_i & (tmo_cnt_q == ~TMO_W'(1));
`else
    assign tmo_hit = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (req_len_i == '0) ? ST_DONE : ST_BURST;
            ST_BURST: if (wbm.wbm_lack_i || tmo_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- burst context and sticky status ----------------
    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            we_q       <= 1'b0;
            adr_q      <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            proto_q    <= 1'b0;
        end else if (accept) begin
            we_q       <= req_we_i;
            adr_q      <= req_addr_i & ~AW'(3);
            len_q      <= req_len_i;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            proto_q    <= 1'b0;
        end else if (in_burst) begin
            if (ack_ok) beat_cnt_q <= beat_cnt_q + BL'(1);
            if (wbm.wbm_ack_i && wbm.wbm_err_i) err_q <= 1'b1;
            // Ack beyond the requested length, or lack on the wrong beat.
            if ((wbm.wbm_ack_i && !beat_ok) ||
                (wbm.wbm_lack_i && (beat_cnt_q != len_q - BL'(1))))
                proto_q <= 1'b1;
            if (tmo_hit) begin
                err_q   <= 1'b1;
                proto_q <= 1'b1;
            end
        end
    end

`ifdef YCR1_WBM_BURST_TMO_EN
    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else if (accept) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else if (in_burst) begin
            if (wbm.wbm_ack_i) tmo_cnt_q <= '0;
            else               tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            if (tmo_hit) tmo_q <= 1'b1;
        end
    end

    assign tmo_o = done_o & tmo_q;
`endif

    // ---------------- outputs ----------------
    assign req_ready_o   = (state_q == ST_IDLE);
    assign dbg_state_o   = state_q;

    assign wbm.wbm_cyc_o = in_burst;
    assign wbm.wbm_stb_o = in_burst;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_we_o  = in_burst & we_q;
    assign wbm.wbm_sel_o = {BW{in_burst}};
    assign wbm.wbm_bl_o  = len_q;
    assign wbm.wbm_dat_o = (in_burst && we_q) ? wr_data_i : '0;

    assign wr_pop_o      = ack_ok & we_q;
    assign wr_idx_o      = beat_cnt_q;

    // Read beats pass straight through from the bus with no register stage.
    assign rd_valid_o    = ack_ok & ~we_q;
    assign rd_data_o     = (in_burst && !we_q) ? wbm.wbm_dat_i : '0;
    assign rd_idx_o      = beat_cnt_q;
    assign rd_last_o     = rd_valid_o & wbm.wbm_lack_i;

    assign done_o        = (state_q == ST_DONE);
    assign err_o         = done_o & err_q;
    assign proto_err_o   = done_o & proto_q;

endmodule

// File: tb/tb_ycr1_wbm_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ycr1_wbm_burst_ctrl
//   Directed bench for ycr1_wbm_burst_ctrl: a table of burst scenarios with
//   hand-computed expectations, a data scoreboard, and hand-written
//   sequences for zero-length requests, stray bus acks, mid-burst reset and
//   (with YCR1_WBM_BURST_TMO_EN) the timeout abort.
// ---------------------------------------------------------------------------
module tb_ycr1_wbm_burst_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int BL = 10;

    // ---------------- clock / reset ----------------
    logic wbm_clk_i = 1'b0;
    logic wbm_rst_n = 1'b0;
    always #5 wbm_clk_i = ~wbm_clk_i;

    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [BL-1:0] req_len_i = '0;
    logic [DW-1:0] wr_data_i = '0;
    logic          wr_pop_o;
    logic [BL-1:0] wr_idx_o;
    logic          rd_valid_o;
    logic [DW-1:0] rd_data_o;
    logic [BL-1:0] rd_idx_o;
    logic          rd_last_o;
    logic          done_o;
    logic          err_o;
    logic          proto_err_o;
    logic [1:0]    dbg_state_o;
`ifdef YCR1_WBM_BURST_TMO_EN
    logic          tmo_o;
`endif

    ycr1_wbm_burst_ctrl_if #(.AW(AW), .DW(DW), .BW(BW), .BL(BL)) wbm_if ();

    ycr1_wbm_burst_ctrl #(
        .AW(AW), .DW(DW), .BW(BW), .BL(BL)
`ifdef YCR1_WBM_BURST_TMO_EN
        , .TMO_W(4)
`endif
    ) dut (
        .wbm_rst_n   (wbm_rst_n),
        .wbm_clk_i   (wbm_clk_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .wr_data_i   (wr_data_i),
        .wr_pop_o    (wr_pop_o),
        .wr_idx_o    (wr_idx_o),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .rd_idx_o    (rd_idx_o),
        .rd_last_o   (rd_last_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .proto_err_o (proto_err_o),
`ifdef YCR1_WBM_BURST_TMO_EN
        .tmo_o       (tmo_o),
`endif
        .dbg_state_o (dbg_state_o),
        .wbm         (wbm_if)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_pat(input int b);
        return 32'h0000_00A0 + DW'(b);
    endfunction

    function automatic logic [DW-1:0] wr_pat(input int b);
        return 32'hC0DE_0000 + DW'(b);
    endfunction

    // stb must stay low for at least two sampled cycles between bursts.
    int   low_run = 0;
    logic had_burst = 1'b0;
    always @(negedge wbm_clk_i) begin
        if (!wbm_rst_n) begin
            low_run   = 0;
            had_burst = 1'b0;
        end else if (wbm_if.wbm_stb_o) begin
            if (had_burst && low_run != 0) check("stb_gap_ge2", 64'(low_run >= 2), 64'd1);
            low_run   = 0;
            had_burst = 1'b1;
        end else begin
            low_run++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        wbm_if.wbm_ack_i  = 1'b0;
        wbm_if.wbm_lack_i = 1'b0;
        wbm_if.wbm_err_i  = 1'b0;
        wbm_if.wbm_dat_i  = '0;
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [BL-1:0] len;
        int            acks;       // acks the slave returns
        int            lack_beat;  // beat carrying lack
        int            err_beat;   // beat carrying err (-1 none)
        int            gap;        // idle cycles before each ack
        logic [AW-1:0] exp_adr;
        logic          exp_err;
        logic          exp_proto;
        int            exp_beats;  // beats delivered to the requester
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int exp_idx;
        logic exp_valid;
        for (int b = 0; b < v.exp_beats; b++) exp_q.push_back(v.we ? wr_pat(b) : rd_pat(b));
        // acceptance cycle
        @(posedge wbm_clk_i); #1;
        req_valid_i = 1'b1; req_we_i = v.we; req_addr_i = v.addr; req_len_i = v.len;
        #2 check("req_ready_idle", req_ready_o, 1);
        for (int b = 0; b < v.acks; b++) begin
            for (int g = 0; g <= v.gap; g++) begin
                @(posedge wbm_clk_i); #1;
                req_valid_i = 1'b0;
                wr_data_i   = wr_pat(b);
                wbm_if.wbm_dat_i  = rd_pat(b);
                wbm_if.wbm_ack_i  = (g == v.gap);
                wbm_if.wbm_lack_i = (g == v.gap) && (b == v.lack_beat);
                wbm_if.wbm_err_i  = (g == v.gap) && (b == v.err_beat);
                #2;
                check("burst_stb", wbm_if.wbm_stb_o, 1);
                check("burst_adr", wbm_if.wbm_adr_o, v.exp_adr);
                if (b == 0 && g == 0) begin
                    check("burst_cyc", wbm_if.wbm_cyc_o, 1);
                    check("burst_bl", wbm_if.wbm_bl_o, v.len);
                    check("burst_we", wbm_if.wbm_we_o, v.we);
                    check("burst_sel", wbm_if.wbm_sel_o, 4'hF);
                    check("burst_ready", req_ready_o, 0);
                end
                if (g != v.gap) begin
                    check("gap_no_beat", rd_valid_o | wr_pop_o, 0);
                end else begin
                    exp_idx   = (b < int'(v.len)) ? b : int'(v.len);
                    exp_valid = (b < int'(v.len));
                    if (v.we) begin
                        check("wr_idx", wr_idx_o, exp_idx);
                        check("wr_pop", wr_pop_o, exp_valid);
                        check("wr_dat", wbm_if.wbm_dat_o, wr_pat(b));
                        check("wr_no_rd", rd_valid_o, 0);
                        if (wr_pop_o && exp_q.size() != 0) check("sb_wr", wbm_if.wbm_dat_o, exp_q.pop_front());
                    end else begin
                        check("rd_idx", rd_idx_o, exp_idx);
                        check("rd_valid", rd_valid_o, exp_valid);
                        check("rd_last", rd_last_o, exp_valid && (b == v.lack_beat));
                        check("rd_no_pop", wr_pop_o, 0);
                        if (rd_valid_o && exp_q.size() != 0) check("sb_rd", rd_data_o, exp_q.pop_front());
                    end
                end
            end
        end
        // DONE cycle
        @(posedge wbm_clk_i); #1;
        bus_idle();
        #2;
        check("done_pulse", done_o, 1);
        check("done_err", err_o, v.exp_err);
        check("done_proto", proto_err_o, v.exp_proto);
        check("done_stb_low", wbm_if.wbm_stb_o | wbm_if.wbm_cyc_o, 0);
        check("done_not_ready", req_ready_o, 0);
        // back in IDLE
        @(posedge wbm_clk_i); #3;
        check("idle_done_low", done_o, 0);
        check("idle_ready", req_ready_o, 1);
        check("idle_stb_low", wbm_if.wbm_stb_o, 0);
        check("sb_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int stb_cycles;
        bus_idle();

        // Vector table: we, addr, len, acks, lack_beat, err_beat, gap, exp_adr, exp_err, exp_proto, exp_beats
        vecs[0] = '{1'b0, 32'h1000_0006, 10'd4, 4, 3, -1, 0, 32'h1000_0004, 1'b0, 1'b0, 4}; // refill
        vecs[1] = '{1'b1, 32'h2000_0010, 10'd3, 3, 2, -1, 2, 32'h2000_0010, 1'b0, 1'b0, 3}; // writeback, spaced acks
        vecs[2] = '{1'b0, 32'h3000_0003, 10'd8, 8, 7,  2, 0, 32'h3000_0000, 1'b1, 1'b0, 8}; // bus error on beat 2
        vecs[3] = '{1'b0, 32'h4000_0000, 10'd4, 2, 1, -1, 0, 32'h4000_0000, 1'b0, 1'b1, 2}; // early lack
        vecs[4] = '{1'b1, 32'h5000_000B, 10'd2, 3, 2, -1, 1, 32'h5000_0008, 1'b0, 1'b1, 2}; // ack overrun

        // reset state
        repeat (3) @(posedge wbm_clk_i);
        #3;
        check("rst_ready", req_ready_o, 1);
        check("rst_stb_cyc", {wbm_if.wbm_stb_o, wbm_if.wbm_cyc_o}, 0);
        check("rst_adr", wbm_if.wbm_adr_o, 0);
        check("rst_bl", wbm_if.wbm_bl_o, 0);
        check("rst_sel_we", {wbm_if.wbm_sel_o, wbm_if.wbm_we_o}, 0);
        check("rst_beats", {rd_valid_o, wr_pop_o, rd_last_o}, 0);
        check("rst_status", {done_o, err_o, proto_err_o}, 0);
        check("rst_state", dbg_state_o, 0);
        @(negedge wbm_clk_i);
        wbm_rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // zero-length request: straight to DONE, flags cleared after the proto burst
        @(posedge wbm_clk_i); #1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h6000_0000; req_len_i = '0;
        #2 check("len0_ready", req_ready_o, 1);
        @(posedge wbm_clk_i); #1;
        req_valid_i = 1'b0;
        #2;
        check("len0_done", done_o, 1);
        check("len0_no_stb", wbm_if.wbm_stb_o, 0);
        check("len0_flags", {err_o, proto_err_o}, 0);
        @(posedge wbm_clk_i); #3;
        check("len0_idle", {req_ready_o, done_o, wbm_if.wbm_stb_o}, 3'b100);

        // bus responses outside a burst are ignored
        @(posedge wbm_clk_i); #1;
        wbm_if.wbm_ack_i = 1'b1; wbm_if.wbm_lack_i = 1'b1; wbm_if.wbm_err_i = 1'b1;
        wbm_if.wbm_dat_i = 32'hDEAD_BEEF;
        #2;
        check("stray_no_rd", {rd_valid_o, rd_last_o, wr_pop_o}, 0);
        check("stray_rd_data", rd_data_o, 0);
        @(posedge wbm_clk_i); #1;
        bus_idle();
        #2 check("stray_idle", {req_ready_o, done_o, wbm_if.wbm_stb_o}, 3'b100);

        // reset in the middle of a 16-beat refill
        @(posedge wbm_clk_i); #1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h7000_0040; req_len_i = 10'd16;
        for (int b = 0; b < 3; b++) begin
            @(posedge wbm_clk_i); #1;
            req_valid_i = 1'b0;
            wbm_if.wbm_ack_i = 1'b1; wbm_if.wbm_dat_i = rd_pat(b);
        end
        @(posedge wbm_clk_i); #1;
        #1 check("mid_rst_pre_stb", wbm_if.wbm_stb_o, 1);
        check("mid_rst_pre_idx", rd_idx_o, 3);
        wbm_rst_n = 1'b0;
        #1;
        check("mid_rst_stb_cyc", {wbm_if.wbm_stb_o, wbm_if.wbm_cyc_o}, 0);
        check("mid_rst_ready", req_ready_o, 1);
        check("mid_rst_rd", {rd_valid_o, rd_last_o}, 0);
        check("mid_rst_idx", rd_idx_o, 0);
        check("mid_rst_adr_bl", {wbm_if.wbm_adr_o, wbm_if.wbm_bl_o}, 0);
        check("mid_rst_state", dbg_state_o, 0);
        bus_idle();
        @(negedge wbm_clk_i);
        wbm_rst_n = 1'b1;

        // normal operation resumes after reset
        run_vec(vecs[0]);

`ifdef YCR1_WBM_BURST_TMO_EN
        // silent slave: watchdog aborts after 15 burst cycles
        @(posedge wbm_clk_i); #1;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h8000_0000; req_len_i = 10'd2;
        stb_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge wbm_clk_i); #1;
            req_valid_i = 1'b0;
            #2;
            if (!wbm_if.wbm_stb_o) break;
            stb_cycles++;
        end
        check("tmo_burst_cycles", stb_cycles, 15);
        check("tmo_done", done_o, 1);
        check("tmo_flags", {err_o, proto_err_o, tmo_o}, 3'b111);
`else
        stb_cycles = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ycr1_wbm_burst_ctrl.md
Name: ycr1_wbm_burst_ctrl

Overview:
- Wishbone burst master that sits directly upstream of the async Wishbone bridge, in the wbm_clk_i domain.
- Turns a single cache-line refill (read) or writeback (write) request into one Wishbone burst: wbm_bl_o beats, terminated by wbm_lack_i.
- Streams read beats to the requester, pulls write beats from it, and reports completion and error status.

Parameters:
- AW, 32, address width
- DW, 32, data width
- BW, 4, byte-enable width (DW/8)
- BL, 10, burst-count width; max burst = 2^BL-1 beats
- TMO_W, 8, timeout counter width (used only with the optional feature)

Ports:
- wbm_rst_n  in  1  asynchronous active-low reset
- wbm_clk_i  in  1  clock
- req_valid_i  in  1  burst request
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = writeback, 0 = refill
- req_addr_i  in  AW  start byte address
- req_len_i  in  BL  beat count
- wr_data_i  in  DW  current write beat; must be valid while wr_idx_o points to it
- wr_pop_o  out  1  write beat consumed this cycle
- wr_idx_o  out  BL  index of the current write beat
- rd_valid_o  out  1  read beat valid
- rd_data_o  out  DW  read beat
- rd_idx_o  out  BL  index of the read beat
- rd_last_o  out  1  final read beat
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  status, valid with done_o: bus error seen
- proto_err_o  out  1  status, valid with done_o: lack/length mismatch
- wbm_cyc_o, wbm_stb_o  out  1  Wishbone cycle/strobe
- wbm_adr_o  out  AW  burst start address, word aligned
- wbm_we_o  out  1  write
- wbm_dat_o  out  DW  write data
- wbm_sel_o  out  BW  byte enables
- wbm_bl_o  out  BL  burst length
- wbm_dat_i  in  DW  read data
- wbm_ack_i  in  1  beat ack
- wbm_lack_i  in  1  last-beat ack
- wbm_err_i  in  1  error

Behaviour:
- Reset values: every output 0 except req_ready_o=1. State is IDLE; counters and sticky flags are cleared.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - req_ready_o=1.
  - On valid&ready with req_len_i!=0: latch we, addr with bits[1:0] forced to 0, and len; clear beat_cnt, err and proto flags; go to BURST.
  - On valid&ready with req_len_i==0: go to DONE with no bus activity; err=0, proto=0.
- BURST:
  - cyc=stb=1. wbm_adr_o, wbm_we_o and wbm_bl_o are held constant for the whole burst. wbm_sel_o is all ones.
  - wbm_stb_o rises exactly 1 cycle after request acceptance.
- Each wbm_ack_i in BURST:
  - beat_cnt increments, saturating at len.
  - Write: wbm_dat_o=wr_data_i, wr_idx_o=beat_cnt, wr_pop_o=wbm_ack_i (combinational).
  - Read: rd_valid_o=wbm_ack_i, rd_data_o=wbm_dat_i, rd_idx_o=beat_cnt, rd_last_o=wbm_lack_i. All combinational, zero-latency pass-through.
  - wbm_err_i with ack sets sticky err. The burst continues to lack; it is never dropped early.
- Acks beyond len beats: suppress rd_valid_o/wr_pop_o and set proto.
- wbm_lack_i in BURST:
  - If asserted while beat_cnt != len-1: set proto.
  - In all cases go to DONE; cyc/stb fall the next cycle.
- DONE:
  - stb=cyc=0, done_o=1, err_o/proto_err_o reflect the sticky flags.
  - Next state is IDLE.
  - stb is therefore low for at least 2 cycles between bursts, which satisfies the downstream stb-gap rule.
- Sticky flags are held until the next acceptance; err_o/proto_err_o are meaningful only with done_o.
- ack/lack/err outside BURST are ignored.
- Reset asserted mid-burst: immediate return to reset values. The downstream is reset by the same system reset.

Optional Feature:
- Macro: YCR1_WBM_BURST_TMO_EN.
- Enabled:
  - A TMO_W counter clears on acceptance and on every wbm_ack_i, and increments each BURST cycle.
  - When it reaches all ones: abort to DONE with err=1, proto=1, and assert extra output tmo_o=1 with done_o.
  - An abort leaves the downstream in an undefined state; system reset is required.
- Disabled: no counter, tmo_o port absent, BURST waits indefinitely.

Test Plan:
- Refill: req_we=0, addr=0x1000_0006, len=4; slave acks 4 beats, data A0..A3, lack on 4th -> wbm_adr_o=0x1000_0004, bl=4, rd_idx 0..3, rd_last on beat 3, done_o 1 cycle after lack, err=proto=0.
- Writeback: req_we=1, len=3, wr_data follows wr_idx; slave acks with 2 idle cycles between beats -> wbm_dat_o matches the beat at each ack, 3 wr_pop pulses, done, stb low ≥2 cycles before the next request's stb.
- Error: len=8, wbm_err_i on beat 2 -> all 8 beats still delivered, done with err_o=1, proto_err_o=0.
- Early lack: len=4, lack on beat 2 -> done with proto_err_o=1, rd_last on beat 2, idle after.
- len=0 request -> no stb, done_o 1 cycle after acceptance, flags 0. Then reset pulse mid-burst on a len=16 burst -> all outputs return to reset values in the same cycle.
- (TMO_EN, TMO_W=4) len=2, no ack -> abort after 15 BURST cycles, done with err=proto=tmo=1.
